// File: rtl/cache_pkg.sv
// Shared definitions for the cache memory-side blocks: line/burst geometry
// and the cacheline adaptor state encoding.
package cache_pkg;

   localparam int S_LINE      = 256;
   localparam int S_BURST     = 64;
   localparam int N_BEATS     = S_LINE / S_BURST;
   localparam int LINE_OFFSET = 5;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      DONE
   } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit cache line read/write into a 4-beat 64-bit burst on the
// memory port; one transaction in flight, Moore outputs held in registers.
module cacheline_adaptor
   import cache_pkg::*;
#(
   parameter int s_line  = S_LINE,
   parameter int s_burst = S_BURST
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [s_line-1:0]   line_i,
   output logic [s_line-1:0]   line_o,
   input  logic [31:0]         address_i,
   input  logic                read_i,
   input  logic                write_i,
   output logic                resp_o,
   input  logic [s_burst-1:0]  burst_i,
   output logic [s_burst-1:0]  burst_o,
   output logic [31:0]         address_o,
   output logic                read_o,
   output logic                write_o,
   input  logic                resp_i
);

   localparam int n_beats           = s_line / s_burst;
   localparam int cw                = (n_beats > 1) ? $clog2(n_beats) : 1;
   localparam logic [cw-1:0] last_beat = cw'(n_beats - 1);
   localparam logic [31:0] line_mask = ~((32'd1 << LINE_OFFSET) - 32'd1);

   adaptor_state_t state;
   logic [cw-1:0]     count;
   logic [s_line-1:0] buffer;
   logic [31:0]       addr;

   assign line_o    = buffer;
   assign address_o = addr;
   assign burst_o   = buffer[s_burst*int'(count) +: s_burst];

   // read_o/write_o/resp_o are set on the same edge that enters the state
   // they belong to, so they always equal a decode of the registered state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         count   <= '0;
         buffer  <= '0;
         addr    <= '0;
         read_o  <= 1'b0;
         write_o <= 1'b0;
         resp_o  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (write_i) begin
                  buffer  <= line_i;
                  addr    <= address_i & line_mask;
                  count   <= '0;
                  state   <= WRITE;
                  write_o <= 1'b1;
               end else if (read_i) begin
                  addr   <= address_i & line_mask;
                  count  <= '0;
                  state  <= READ;
                  read_o <= 1'b1;
               end
            end
            READ: begin
               if (resp_i) begin
                  buffer[s_burst*int'(count) +: s_burst] <= burst_i;
                  count <= count + 1'b1;
                  if (count == last_beat) begin
                     state  <= DONE;
                     read_o <= 1'b0;
                     resp_o <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (resp_i) begin
                  count <= count + 1'b1;
                  if (count == last_beat) begin
                     state   <= DONE;
                     write_o <= 1'b0;
                     resp_o  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state  <= IDLE;
               resp_o <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               read_o  <= 1'b0;
               write_o <= 1'b0;
               resp_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule
